// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, constants and fetch FSM state type for the RV32I core
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int PCMUX_SEQ = 0;
    localparam int PCMUX_TGT = 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: request/grant/response instruction-memory port
interface instr_fetch_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic req;
    logic [XLEN-1:0] addr;
    logic gnt;
    logic rvalid;
    logic [XLEN-1:0] rdata;
    logic err;
    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter register, pc+4 adder and next-PC select
module pc_unit import riscv_pkg::*; #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int pcmux_N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pcnextctl,
    input  logic [$clog2(pcmux_N)-1:0] pcmuxctl,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    logic [XLEN-1:0] pc_next;
    // unused select codes fall back to sequential
    assign pc_plus4 = pc + XLEN'(4);
    assign pc_next = (int'(pcmuxctl) == PCMUX_TGT) ? pc_target : pc_plus4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (pcnextctl)
            pc <= pc_next;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch FSM issuing one memory transaction per request and holding the fetched word
module instr_fetch_unit import riscv_pkg::*; #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int pcmux_N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic instrre,
    input  logic pcnextctl,
    input  logic [$clog2(pcmux_N)-1:0] pcmuxctl,
    input  logic [XLEN-1:0] pc_target,
    instr_fetch_unit_if.master imem,
    output logic [XLEN-1:0] instr,
    output logic instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic fetch_busy,
    output logic fetch_fault
);
    fetch_state_t state, state_n;
    logic [XLEN-1:0] fetch_addr, addr_n, instr_n;
    logic valid_n, fault_n;

    pc_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .pcmux_N(pcmux_N)) u_pc (
        .clk(clk),
        .rst_n(rst_n),
        .pcnextctl(pcnextctl),
        .pcmuxctl(pcmuxctl),
        .pc_target(pc_target),
        .pc(pc),
        .pc_plus4(pc_plus4)
    );

    assign imem.addr = fetch_addr;

    always_comb begin
        state_n = state;
        addr_n = fetch_addr;
        instr_n = instr;
        valid_n = 1'b0;
        fault_n = 1'b0;
        case (state)
            IDLE: if (instrre) begin
                state_n = (pc[1:0] == 2'b00) ? REQ : IDLE;
                addr_n = (pc[1:0] == 2'b00) ? pc : fetch_addr;
                fault_n = (pc[1:0] != 2'b00);
            end
            REQ: state_n = imem.gnt ? WAIT : REQ;
            WAIT: if (imem.rvalid) begin
                state_n = IDLE;
                fault_n = imem.err;
                valid_n = !imem.err;
                instr_n = imem.err ? instr : imem.rdata;
            end
            default: state_n = IDLE;
        endcase
    end

    // req and busy are registered copies of the next state so they drop with the async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fetch_addr <= '0;
            instr <= XLEN'(NOP_INSTR);
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_busy <= 1'b0;
            imem.req <= 1'b0;
        end else begin
            state <= state_n;
            fetch_addr <= addr_n;
            instr <= instr_n;
            instr_valid <= valid_n;
            fetch_fault <= fault_n;
            fetch_busy <= (state_n != IDLE);
            imem.req <= (state_n == REQ);
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven fetch vectors, corner sequences and randomized model check
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic instrre = 1'b0;
    logic pcnextctl = 1'b0;
    logic [0:0] pcmuxctl = 1'b0;
    logic [31:0] pc_target = '0;
    logic [31:0] instr, pc, pc_plus4;
    logic instr_valid, fetch_busy, fetch_fault;
    int n_vec = 0;
    int n_bad = 0;

    instr_fetch_unit_if #(.XLEN(32)) imem ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .pcmux_N(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instrre(instrre),
        .pcnextctl(pcnextctl),
        .pcmuxctl(pcmuxctl),
        .pc_target(pc_target),
        .imem(imem),
        .instr(instr),
        .instr_valid(instr_valid),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .fetch_busy(fetch_busy),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int gd;
        int rd;
        logic err;
        logic [31:0] rdata;
        int lat;
        logic [31:0] instr;
        logic fault;
        int reqs;
        logic [31:0] pcp4;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] t);
        pcnextctl = 1'b1;
        pcmuxctl = 1'b1;
        pc_target = t;
        step();
        pcnextctl = 1'b0;
    endtask

    // memory responder: grant after gd stalled REQ cycles, respond rd cycles after grant
    task automatic run_fetch(input int gd, input int rd, input logic err, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, output int lat, output int reqs,
                             output int addr_bad, output logic v, output logic f);
        int gc;
        int wc;
        bit waiting;
        gc = 0;
        wc = 0;
        waiting = 0;
        lat = 99;
        reqs = 0;
        addr_bad = 0;
        v = 1'b0;
        f = 1'b0;
        instrre = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            instrre = 1'b0;
            imem.gnt = 1'b0;
            imem.rvalid = 1'b0;
            imem.err = 1'b0;
            if (instr_valid || fetch_fault) begin
                lat = c;
                v = instr_valid;
                f = fetch_fault;
                break;
            end
            if (imem.req) begin
                reqs++;
                if (imem.addr !== exp_addr) addr_bad++;
                if (gc == gd) begin
                    imem.gnt = 1'b1;
                    waiting = 1;
                end else gc++;
            end else if (waiting) begin
                if (wc == rd) begin
                    imem.rvalid = 1'b1;
                    imem.err = err;
                    imem.rdata = rdata;
                    waiting = 0;
                end else wc++;
            end
        end
    endtask

    initial begin
        int lat, reqs, abad;
        logic v, f;
        logic [31:0] m_pc, m_instr, m_addr, t;
        bit m_busy, m_granted, e_valid, e_fault;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        imem.err = 1'b0;
        imem.rdata = '0;
        tbl[0] = '{32'h0000_0000, 0, 0, 1'b0, 32'h0050_0093, 3, 32'h0050_0093, 1'b0, 1, 32'h0000_0004};
        tbl[1] = '{32'h0000_0040, 3, 0, 1'b0, 32'h1111_1111, 6, 32'h1111_1111, 1'b0, 4, 32'h0000_0044};
        tbl[2] = '{32'h0000_0080, 0, 2, 1'b0, 32'h2222_2222, 5, 32'h2222_2222, 1'b0, 1, 32'h0000_0084};
        tbl[3] = '{32'h0000_0102, 0, 0, 1'b0, 32'h9999_9999, 1, 32'h2222_2222, 1'b1, 0, 32'h0000_0106};
        tbl[4] = '{32'h0000_0200, 1, 1, 1'b1, 32'hDEAD_BEEF, 5, 32'h2222_2222, 1'b1, 2, 32'h0000_0204};
        tbl[5] = '{32'hFFFF_FFFC, 2, 1, 1'b0, 32'h3333_3333, 6, 32'h3333_3333, 1'b0, 3, 32'h0000_0000};

        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_ctrl", {28'h0, instr_valid, imem.req, fetch_busy, fetch_fault}, 32'h0);
        chk("rst_addr", imem.addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            set_pc(tbl[i].pc);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, tbl[i].pcp4);
            run_fetch(tbl[i].gd, tbl[i].rd, tbl[i].err, tbl[i].rdata, tbl[i].pc, lat, reqs, abad, v, f);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_fault", i), f, tbl[i].fault);
            chk($sformatf("v%0d_valid", i), v, !tbl[i].fault);
            chk($sformatf("v%0d_instr", i), instr, tbl[i].instr);
            chk($sformatf("v%0d_req_cycles", i), reqs, tbl[i].reqs);
            chk($sformatf("v%0d_addr_stable", i), abad, 0);
            step();
            chk($sformatf("v%0d_pulse_width", i), {instr_valid, fetch_fault}, 0);
        end

        pcnextctl = 1'b1;
        pcmuxctl = 1'b0;
        step();
        pcnextctl = 1'b0;
        chk("wrap_pc", pc, 32'h0);

        set_pc(32'h20);
        instrre = 1'b1;
        step();
        instrre = 1'b0;
        chk("upd_req", imem.req, 1'b1);
        chk("upd_addr", imem.addr, 32'h20);
        imem.gnt = 1'b1;
        step();
        imem.gnt = 1'b0;
        chk("upd_wait_req", {imem.req, fetch_busy}, 2'b01);
        pcnextctl = 1'b1;
        pcmuxctl = 1'b1;
        pc_target = 32'h100;
        step();
        pcnextctl = 1'b0;
        chk("upd_pc_in_wait", pc, 32'h100);
        chk("upd_addr_held", imem.addr, 32'h20);
        imem.rvalid = 1'b1;
        imem.rdata = 32'hAAAA_0001;
        step();
        imem.rvalid = 1'b0;
        chk("upd_valid", instr_valid, 1'b1);
        chk("upd_instr", instr, 32'hAAAA_0001);
        pcnextctl = 1'b1;
        pcmuxctl = 1'b0;
        step();
        pcnextctl = 1'b0;
        chk("upd_pc_seq", pc, 32'h104);

        instrre = 1'b1;
        pcnextctl = 1'b1;
        pcmuxctl = 1'b1;
        pc_target = 32'h300;
        step();
        instrre = 1'b0;
        pcnextctl = 1'b0;
        chk("sim_addr_old_pc", imem.addr, 32'h104);
        chk("sim_pc_new", pc, 32'h300);
        imem.gnt = 1'b1;
        step();
        imem.gnt = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata = 32'hBBBB_0002;
        step();
        imem.rvalid = 1'b0;
        chk("sim_instr", instr, 32'hBBBB_0002);

        instrre = 1'b1;
        step();
        instrre = 1'b0;
        chk("mid_req", imem.req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req_async", imem.req, 1'b0);
        chk("mid_pc", pc, 32'h0);
        chk("mid_busy", fetch_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        imem.rvalid = 1'b1;
        imem.rdata = 32'hFFFF_FFFF;
        step();
        imem.rvalid = 1'b0;
        chk("late_rvalid", {instr_valid, fetch_fault}, 0);
        chk("late_instr", instr, 32'h0000_0013);

        // random run against a transaction-level model: one outstanding fetch, PC arithmetic
        m_pc = 32'h0;
        m_instr = 32'h0000_0013;
        m_addr = 32'h0;
        m_busy = 0;
        m_granted = 0;
        e_valid = 0;
        e_fault = 0;
        for (int i = 0; i < 300; i++) begin
            chk("rnd_pc", pc, m_pc);
            chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("rnd_valid", instr_valid, e_valid);
            chk("rnd_fault", fetch_fault, e_fault);
            chk("rnd_instr", instr, m_instr);
            chk("rnd_busy", fetch_busy, m_busy);
            chk("rnd_req", imem.req, m_busy && !m_granted);
            if (m_busy && !m_granted) chk("rnd_addr", imem.addr, m_addr);
            t = $urandom;
            if ($urandom_range(7) != 0) t[1:0] = 2'b00;
            instrre = 1'($urandom_range(1));
            pcnextctl = ($urandom_range(3) == 0);
            pcmuxctl = 1'($urandom_range(1));
            pc_target = t;
            imem.gnt = 1'b0;
            imem.rvalid = 1'b0;
            imem.err = 1'b0;
            if (m_busy && !m_granted) imem.gnt = 1'($urandom_range(1));
            else if (m_busy) begin
                imem.rvalid = 1'($urandom_range(1));
                imem.err = ($urandom_range(7) == 0);
                imem.rdata = $urandom;
            end
            e_valid = 0;
            e_fault = 0;
            if (!m_busy) begin
                if (instrre && m_pc[1:0] != 2'b00) e_fault = 1;
                else if (instrre) begin
                    m_busy = 1;
                    m_granted = 0;
                    m_addr = m_pc;
                end
            end else if (!m_granted) begin
                if (imem.gnt) m_granted = 1;
            end else if (imem.rvalid) begin
                m_busy = 0;
                if (imem.err) e_fault = 1;
                else begin
                    e_valid = 1;
                    m_instr = imem.rdata;
                end
            end
            if (pcnextctl) m_pc = pcmuxctl ? pc_target : m_pc + 32'd4;
            step();
        end
        instrre = 1'b0;
        pcnextctl = 1'b0;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit for the multi-cycle RV32I core. It owns the program counter and responds to the main controller's fetch request (`instrre`) and PC-update controls (`pcnextctl`, `pcmuxctl`). For each request it runs one request/grant/response transaction on the instruction-memory port and returns the fetched word with a single-cycle `instr_valid` pulse. It sits between the controller FSM and instruction memory, and feeds `instr`, `pc` and `pc_plus4` to decode and the datapath.

## Interface
- `XLEN`, 32: address and data width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `pcmux_N`, 2: number of PC-mux sources. Select width is `$clog2(pcmux_N)`.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instrre`  in  1  fetch request from the controller. Level-sampled and accepted only in IDLE.
- `pcnextctl`  in  1  update the PC this cycle.
- `pcmuxctl`  in  `$clog2(pcmux_N)`  next-PC select: 0 = `pc_plus4`, 1 = `pc_target`.
- `pc_target`  in  XLEN  branch/jump target from the datapath.
- `imem_req`  out  1  memory request; held until granted.
- `imem_addr`  out  XLEN  fetch address; stable while `imem_req`=1.
- `imem_gnt`  in  1  memory accepted the request.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  XLEN  read data.
- `imem_err`  in  1  bus error; qualified by `imem_rvalid`.
- `instr`  out  XLEN  last successfully fetched instruction.
- `instr_valid`  out  1  one-cycle pulse when `instr` is updated.
- `pc`  out  XLEN  current PC.
- `pc_plus4`  out  XLEN  `pc + 4`, combinational, modulo 2^XLEN.
- `fetch_busy`  out  1  high in REQ and WAIT.
- `fetch_fault`  out  1  one-cycle pulse on a misaligned PC or bus error.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - If `instrre`=1 and `pc[1:0]`=0: latch `fetch_addr <= pc`, go to REQ.
  - If `instrre`=1 and `pc[1:0]`≠0: pulse `fetch_fault`, stay in IDLE, issue no request.
- **REQ**
  - `imem_req`=1 and `imem_addr`=`fetch_addr`.
  - On `imem_gnt`=1, go to WAIT.
- **WAIT**
  - `imem_req`=0.
  - On `imem_rvalid`=1 and `imem_err`=0: `instr <= imem_rdata`, pulse `instr_valid`, go to IDLE.
  - On `imem_rvalid`=1 and `imem_err`=1: pulse `fetch_fault`, leave `instr` unchanged, go to IDLE.
- `instrre` is ignored in REQ and WAIT. No request is queued.
- **PC update**
  - On `pcnextctl`=1: `pc <= (pcmuxctl==1) ? pc_target : pc_plus4`.
  - Any select value ≥2 behaves as 0.
  - The update is legal in every state. The in-flight fetch still uses the latched `fetch_addr`.
- **Simultaneous events**
  - `instrre` and `pcnextctl` in the same IDLE cycle: the fetch uses the pre-update PC.
  - `imem_gnt` and `imem_rvalid` are never acted on in the same cycle. `rvalid` is only looked at in WAIT.
- `pc_plus4` wraps: 32'hFFFF_FFFC + 4 = 0.
- **Reset values**
  - `pc` = `RESET_PC`.
  - `instr` = 32'h0000_0013 (NOP).
  - `instr_valid`, `imem_req`, `fetch_busy`, `fetch_fault` = 0.
  - `imem_addr` = 0.
  - State = IDLE.
- **Reset mid-transaction:** `imem_req` drops immediately (asynchronously). Any response that arrives later is ignored because the FSM is in IDLE.

## Timing
- All outputs are registered except `pc_plus4` and `imem_addr`. `imem_addr` is driven from `fetch_addr`, which is itself a register.
- Best-case latency, with `imem_gnt` in the first REQ cycle and `imem_rvalid` in the first WAIT cycle:
  - cycle 0: `instrre` sampled;
  - cycle 1: `imem_req` high;
  - cycle 2: WAIT;
  - cycle 3: `instr_valid` high.
- Each grant stall or response stall adds one cycle.
- `instr_valid` and `fetch_fault` are high for exactly one cycle and are mutually exclusive.
- `pc` changes on the edge where `pcnextctl` is sampled, and is visible the next cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`;
  - `NOP_INSTR` = 32'h0000_0013;
  - `PCMUX_SEQ` = 0 and `PCMUX_TGT` = 1;
  - `fetch_state_t` enum {IDLE, REQ, WAIT}.
- One sub-module, `pc_unit`, contains the PC register, the `pc_plus4` adder and the next-PC mux.
- The fetch FSM and the instruction register stay in `instr_fetch_unit`.

## Test plan
- **Reset and basic fetch:** release reset with `RESET_PC`=0, pulse `instrre`, memory grants immediately and returns 32'h0050_0093 one cycle later → `imem_addr`=0, `instr_valid` in cycle 3, `instr`=32'h0050_0093.
- **Stalled grant:** hold `imem_gnt`=0 for 3 cycles → `imem_req` stays high and `imem_addr` stays stable throughout; `instr_valid` arrives in cycle 6.
- **PC update during WAIT:** `pcnextctl`=1, `pcmuxctl`=1, `pc_target`=32'h100 while in WAIT → the fetch completes from the old address and `pc`=32'h100 afterwards. Then `pcnextctl` with select 0 → `pc`=32'h104.
- **Faults:**
  - `pc_target`=32'h102, then `instrre` → `fetch_fault` pulse, no `imem_req`.
  - `imem_err` on the response → `fetch_fault` pulse and `instr` unchanged.
- **Wrap-around:** `pc`=32'hFFFF_FFFC, `pcnextctl` with select 0 → `pc`=0.
- **Reset mid-operation:** assert `rst_n`=0 in REQ → `imem_req`=0 immediately and `pc`=`RESET_PC`. A late `imem_rvalid` after reset release produces no `instr_valid`.
